// File: rtl/conv_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | conv_pkg: widths, tap constants and rounding/saturation helpers shared  |
// | by the vertical and horizontal convolution passes.   Rev 1.0            |
// +-------------------------------------------------------------------------+
package conv_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_KERNEL_H  = 7;
  localparam int DEF_COEF_W    = 8;
  localparam int DEF_FRAC_BITS = 6;
  localparam int DEF_OUT_W     = 8;

  function automatic int prod_w(input int data_w, input int coef_w);
    return data_w + coef_w + 1;
  endfunction

  function automatic int sum_w(input int p_w, input int taps);
    return p_w + $clog2(taps);
  endfunction

  function automatic int ptr_w(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  // Tap value representing 1.0 in the coefficient fixed-point format.
  function automatic int ident_tap(input int frac_bits);
    return 1 << frac_bits;
  endfunction

  function automatic int round_const(input int frac_bits);
    return 1 << (frac_bits - 1);
  endfunction

  function automatic int sat_hi(input int out_w);
    return (1 << out_w) - 1;
  endfunction

  localparam int SAT_LO = 0;

endpackage
`default_nettype wire

// File: rtl/adder_tree.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | adder_tree: registered signed sum of N packed operands, with enable.    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module adder_tree #(
  parameter int N     = 7,
  parameter int IN_W  = 17,
  parameter int SUM_W = 20
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [N*IN_W-1:0]       i_ops,
  output logic signed [SUM_W-1:0] o_sum
);

  logic signed [SUM_W-1:0] total;
  logic signed [SUM_W-1:0] sum_d;
  logic signed [SUM_W-1:0] sum_q;

  always_comb begin
    total = '0;
    for (int k = 0; k < N; k++) begin
      total = total + SUM_W'($signed(i_ops[k*IN_W +: IN_W]));
    end
    sum_d = i_en ? total : sum_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign o_sum = sum_q;

endmodule
`default_nettype wire

// File: rtl/vertical_conv.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | vertical_conv: vertical pass of the separable convolution; one column   |
// | in, one rounded/saturated pixel out, double-buffered taps.   Rev 1.0    |
// +-------------------------------------------------------------------------+
module vertical_conv
  import conv_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int KERNEL_H  = DEF_KERNEL_H,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int OUT_W     = DEF_OUT_W
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_vld,
  input  logic                         i_eof,
  input  logic [KERNEL_H*DATA_W-1:0]   i_data,
  output logic                         o_rdy,
  input  logic                         i_rdy,
  output logic                         o_vld,
  output logic                         o_eof,
  output logic [OUT_W-1:0]             o_data,
  input  logic                         i_coef_we,
  input  logic [ptr_w(KERNEL_H)-1:0]   i_coef_addr,
  input  logic [COEF_W-1:0]            i_coef_data,
  input  logic                         i_coef_commit,
  output logic                         o_commit_pend
);

  localparam int PROD_W = prod_w(DATA_W, COEF_W);
  localparam int SUM_W  = sum_w(PROD_W, KERNEL_H);
  localparam int CENTER = KERNEL_H / 2;
  localparam logic signed [COEF_W-1:0] IDENT   = COEF_W'(ident_tap(FRAC_BITS));
  localparam logic signed [SUM_W-1:0]  ROUND_K = SUM_W'(round_const(FRAC_BITS));
  localparam logic signed [SUM_W-1:0]  SAT_MAX = SUM_W'(sat_hi(OUT_W));

  logic en, acc;

  logic signed [COEF_W-1:0] shadow_q [KERNEL_H];
  logic signed [COEF_W-1:0] shadow_d [KERNEL_H];
  logic signed [COEF_W-1:0] active_q [KERNEL_H];
  logic signed [COEF_W-1:0] active_d [KERNEL_H];
  logic pend_q, pend_d, in_frame_q, in_frame_d;

  logic [KERNEL_H*PROD_W-1:0] prod_q, prod_d;
  logic signed [PROD_W-1:0]   pix_ext, coef_ext;
  logic s1_vld_q, s1_vld_d, s1_eof_q, s1_eof_d;
  logic s2_vld_q, s2_vld_d, s2_eof_q, s2_eof_d;
  logic signed [SUM_W-1:0] sum_q, rnd, shf;
  logic [OUT_W-1:0] sat_val;
  logic o_vld_q, o_vld_d, o_eof_q, o_eof_d;
  logic [OUT_W-1:0] o_data_q, o_data_d;

  assign en    = !o_vld_q || i_rdy;
  assign acc   = i_vld && en;
  assign o_rdy = en;

  // The active bank only swaps between frames, on a cycle with no accepted beat.
  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    pend_d     = pend_q | i_coef_commit;
    in_frame_d = in_frame_q;
    if (i_coef_we && (int'(i_coef_addr) < KERNEL_H)) begin
      shadow_d[i_coef_addr] = i_coef_data;
    end
    if (pend_q && !in_frame_q && !acc) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end
    if (acc) begin
      in_frame_d = !i_eof;
    end
  end

  always_comb begin
    rnd = sum_q + ROUND_K;
    shf = rnd >>> FRAC_BITS;
    if (shf[SUM_W-1]) begin
      sat_val = '0;
    end else if (shf > SAT_MAX) begin
      sat_val = SAT_MAX[OUT_W-1:0];
    end else begin
      sat_val = shf[OUT_W-1:0];
    end
  end

  always_comb begin
    prod_d   = prod_q;
    pix_ext  = '0;
    coef_ext = '0;
    s1_vld_d = s1_vld_q;
    s1_eof_d = s1_eof_q;
    s2_vld_d = s2_vld_q;
    s2_eof_d = s2_eof_q;
    o_vld_d  = o_vld_q;
    o_eof_d  = o_eof_q;
    o_data_d = o_data_q;
    if (en) begin
      s1_vld_d = i_vld;
      s1_eof_d = i_vld && i_eof;
      for (int k = 0; k < KERNEL_H; k++) begin
        pix_ext  = {{(PROD_W-DATA_W){1'b0}}, i_data[k*DATA_W +: DATA_W]};
        coef_ext = {{(PROD_W-COEF_W){active_q[k][COEF_W-1]}}, active_q[k]};
        prod_d[k*PROD_W +: PROD_W] = pix_ext * coef_ext;
      end
      s2_vld_d = s1_vld_q;
      s2_eof_d = s1_eof_q;
      o_vld_d  = s2_vld_q;
      o_eof_d  = s2_eof_q;
      if (s2_vld_q) begin
        o_data_d = sat_val;
      end
    end
  end

  adder_tree #(
    .N     (KERNEL_H),
    .IN_W  (PROD_W),
    .SUM_W (SUM_W)
  ) u_adder_tree (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (en),
    .i_ops (prod_q),
    .o_sum (sum_q)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < KERNEL_H; k++) begin
        shadow_q[k] <= (k == CENTER) ? IDENT : '0;
        active_q[k] <= (k == CENTER) ? IDENT : '0;
      end
      pend_q     <= 1'b0;
      in_frame_q <= 1'b0;
      prod_q     <= '0;
      s1_vld_q   <= 1'b0;
      s1_eof_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_eof_q   <= 1'b0;
      o_vld_q    <= 1'b0;
      o_eof_q    <= 1'b0;
      o_data_q   <= '0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      in_frame_q <= in_frame_d;
      prod_q     <= prod_d;
      s1_vld_q   <= s1_vld_d;
      s1_eof_q   <= s1_eof_d;
      s2_vld_q   <= s2_vld_d;
      s2_eof_q   <= s2_eof_d;
      o_vld_q    <= o_vld_d;
      o_eof_q    <= o_eof_d;
      o_data_q   <= o_data_d;
    end
  end

  assign o_vld         = o_vld_q;
  assign o_eof         = o_eof_q;
  assign o_data        = o_data_q;
  assign o_commit_pend = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_vertical_conv.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_vertical_conv: directed + randomized bench with a cycle-level        |
// | behavioural model and output scoreboard.   Rev 1.0                      |
// +-------------------------------------------------------------------------+
module tb_vertical_conv;

  localparam int K  = 7;
  localparam int DW = 8;

  logic            i_clk = 1'b0;
  logic            i_rst, i_vld, i_eof, i_rdy;
  logic [K*DW-1:0] i_data;
  logic            o_rdy, o_vld, o_eof, o_commit_pend;
  logic [7:0]      o_data;
  logic            i_coef_we, i_coef_commit;
  logic [2:0]      i_coef_addr;
  logic [7:0]      i_coef_data;

  vertical_conv dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_vld         (i_vld),
    .i_eof         (i_eof),
    .i_data        (i_data),
    .o_rdy         (o_rdy),
    .i_rdy         (i_rdy),
    .o_vld         (o_vld),
    .o_eof         (o_eof),
    .o_data        (o_data),
    .i_coef_we     (i_coef_we),
    .i_coef_addr   (i_coef_addr),
    .i_coef_data   (i_coef_data),
    .i_coef_commit (i_coef_commit),
    .o_commit_pend (o_commit_pend)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Behavioural model: tap banks as integers, expected pixels queued at acceptance.
  typedef struct {int val; bit eof;} exp_t;
  exp_t q[$];
  int   m_shadow[K];
  int   m_act[K];
  bit   m_pend, m_inframe, m_acc, prev_rst;
  int   n_out = 0;
  int   n_eof = 0;

  function automatic int ref_pixel(input logic [K*DW-1:0] col);
    int s;
    s = 0;
    for (int k = 0; k < K; k++) s += int'(col[k*DW +: DW]) * m_act[k];
    s = (s + 32) >>> 6;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  always @(negedge i_clk) begin
    if (i_rst) begin
      q.delete();
      m_pend    = 1'b0;
      m_inframe = 1'b0;
      for (int k = 0; k < K; k++) begin
        m_shadow[k] = (k == 3) ? 64 : 0;
        m_act[k]    = (k == 3) ? 64 : 0;
      end
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        chk("rst_vld", 32'(o_vld), 0);
        chk("rst_eof", 32'(o_eof), 0);
        chk("rst_data", 32'(o_data), 0);
      end
      prev_rst = 1'b0;
      chk("rdy", 32'(o_rdy), 32'(!o_vld || i_rdy));
      chk("pend", 32'(o_commit_pend), 32'(m_pend));
      if (o_vld) begin
        if (q.size() == 0) begin
          chk("spurious_vld", 32'(o_vld), 0);
        end else begin
          chk("data", 32'(o_data), q[0].val);
          chk("eof", 32'(o_eof), 32'(q[0].eof));
          if (i_rdy) begin
            void'(q.pop_front());
            n_out++;
            if (o_eof) n_eof++;
          end
        end
      end else begin
        chk("eof_no_vld", 32'(o_eof), 0);
      end
      m_acc = i_vld && (!o_vld || i_rdy);
      if (m_acc) q.push_back('{ref_pixel(i_data), i_eof});
      if (m_pend && !m_inframe && !m_acc) begin
        m_act  = m_shadow;
        m_pend = 1'b0;
      end else if (i_coef_commit) begin
        m_pend = 1'b1;
      end
      if (i_coef_we && int'(i_coef_addr) < K) m_shadow[i_coef_addr] = int'($signed(i_coef_data));
      if (m_acc) m_inframe = !i_eof;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input int val);
    i_coef_we   = 1'b1;
    i_coef_addr = addr[2:0];
    i_coef_data = val[7:0];
    tick();
    i_coef_we = 1'b0;
  endtask

  task automatic load_taps(input int t[K], input bit commit);
    for (int k = 0; k < K; k++) write_coef(k, t[k]);
    write_coef(7, 8'h55);
    if (commit) begin
      i_coef_commit = 1'b1;
      tick();
      i_coef_commit = 1'b0;
      chk("pend_set", 32'(o_commit_pend), 1);
      tick();
      tick();
      chk("pend_clr", 32'(o_commit_pend), 0);
    end
  endtask

  // Single beat with directed expected value and 3-cycle latency check.
  task automatic one_beat(input string tag, input logic [K*DW-1:0] col, input bit eofv,
                          input int expd);
    int lat;
    chk({tag, "_rdy"}, 32'(o_rdy), 1);
    i_vld  = 1'b1;
    i_eof  = eofv;
    i_data = col;
    tick();
    i_vld = 1'b0;
    i_eof = 1'b0;
    lat   = 1;
    while (!o_vld && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_data"}, 32'(o_data), expd);
    chk({tag, "_eof"}, 32'(o_eof), 32'(eofv));
    tick();
  endtask

  task automatic send_frame(input int n, input int stall_at, input int stall_len,
                            input int commit_at, input bit last_eof);
    int          sent, cyc;
    bit          acc_now, committed;
    logic [63:0] r64;
    sent      = 0;
    cyc       = 0;
    committed = 1'b0;
    r64       = {$urandom(), $urandom()};
    while (sent < n && cyc < 200) begin
      i_vld         = 1'b1;
      i_eof         = last_eof && (sent == n - 1);
      i_data        = r64[K*DW-1:0];
      i_rdy         = !(cyc >= stall_at && cyc < stall_at + stall_len);
      i_coef_commit = (sent == commit_at) && !committed;
      if (i_coef_commit) committed = 1'b1;
      @(negedge i_clk);
      acc_now = o_rdy;
      if (!i_rdy && o_vld) chk("stall_rdy_low", 32'(o_rdy), 0);
      tick();
      i_coef_commit = 1'b0;
      if (acc_now) begin
        sent++;
        r64 = {$urandom(), $urandom()};
      end
      cyc++;
    end
    chk("frame_sent", sent, n);
    i_vld = 1'b0;
    i_eof = 1'b0;
    i_rdy = 1'b1;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((q.size() != 0 || o_vld) && c < 50) begin
      tick();
      c++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic [K*DW-1:0] col;
    int              taps[K];
    int              base_out, base_eof;
    logic [7:0]      px;

    i_rst = 1'b1; i_vld = 1'b0; i_eof = 1'b0; i_rdy = 1'b1; i_data = '0;
    i_coef_we = 1'b0; i_coef_addr = '0; i_coef_data = '0; i_coef_commit = 1'b0;
    repeat (3) tick();
    chk("reset_vld", 32'(o_vld), 0);
    chk("reset_pend", 32'(o_commit_pend), 0);
    i_rst = 1'b0;
    tick();

    // Passthrough of the centre row with reset taps.
    col = '1;
    col[3*DW +: DW] = 8'h5A;
    one_beat("pass", col, 1'b0, 8'h5A);
    send_frame(1, -1, 0, -1, 1'b1);
    drain();

    // Box filter, 9/64 per tap.
    for (int k = 0; k < K; k++) taps[k] = 9;
    load_taps(taps, 1'b1);
    col = {K{8'h70}};
    one_beat("box", col, 1'b1, 8'h6E);

    // Saturation high and low.
    for (int k = 0; k < K; k++) taps[k] = 0;
    taps[3] = 127;
    load_taps(taps, 1'b1);
    col = {$urandom(), $urandom()};
    col[3*DW +: DW] = 8'hFF;
    one_beat("sat_hi", col, 1'b1, 8'hFF);
    taps[3] = -64;
    load_taps(taps, 1'b1);
    col[3*DW +: DW] = 8'h10;
    one_beat("sat_lo", col, 1'b1, 8'h00);

    // Random taps, 10-beat frame with a 4-cycle downstream stall.
    for (int k = 0; k < K; k++) taps[k] = int'($urandom_range(56)) - 16;
    load_taps(taps, 1'b1);
    base_out = n_out;
    base_eof = n_eof;
    send_frame(10, 4, 4, -1, 1'b1);
    drain();
    chk("bp_count", n_out - base_out, 10);
    chk("bp_eof_count", n_eof - base_eof, 1);

    // Commit requested mid-frame is deferred until the frame ends.
    for (int k = 0; k < K; k++) taps[k] = int'($urandom_range(40)) - 8;
    load_taps(taps, 1'b0);
    send_frame(5, -1, 0, 2, 1'b1);
    chk("defer_pend_hold", 32'(o_commit_pend), 1);
    tick();
    chk("defer_pend_clr", 32'(o_commit_pend), 0);
    send_frame(5, 2, 3, -1, 1'b1);
    drain();

    // Reset with beats in flight.
    send_frame(3, -1, 0, -1, 1'b0);
    i_rst = 1'b1;
    tick();
    chk("midrst_vld", 32'(o_vld), 0);
    i_rst = 1'b0;
    base_out = n_out;
    repeat (6) tick();
    chk("midrst_no_stale", n_out - base_out, 0);
    px  = 8'($urandom_range(255));
    col = {$urandom(), $urandom()};
    col[3*DW +: DW] = px;
    one_beat("midrst_ident", col, 1'b1, int'(px));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
